div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle divider sequencer for the EX stage; produces the 64-bit HI/LO pair written by DIV/DIVU.
- The result travels down the pipeline on the hi/lo path (mem_hi/mem_lo/mem_whilo) to the write-back register.
- Runs a radix-2 restoring shift-subtract state machine and raises a stall request while busy.
- Supports signed and unsigned division, divide-by-zero and annulment on flush.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH wide. Only 32 is required to work; the iteration counter is sized for WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high (`RstEnable = 1)
- start_i  input  1  EX requests a division; held high until ready_o is seen
- annul_i  input  1  flush; abort any division in progress
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  input  WIDTH  dividend; sampled only in FREE when a start is accepted
- opdata2_i  input  WIDTH  divisor; sampled only in FREE when a start is accepted
- result_o  output  2*WIDTH  bits [63:32] = remainder (HI), bits [31:0] = quotient (LO)
- ready_o  output  1  result_o valid
- stallreq_o  output  1  combinational: start_i & ~ready_o

Behaviour:
- Reset (sync, rst=1): state=FREE, cnt=0, result_o=0, ready_o=0, all internal registers cleared. Applies in any state, including mid-division.
- States: FREE, DIVBYZERO, ON, END (2-bit encoding).
- FREE, start_i=1 and annul_i=0:
  - divisor==0 -> DIVBYZERO.
  - otherwise -> ON, cnt=0.
  - Operands are latched. When signed_div_i=1, each negative operand is replaced by its two's-complement magnitude.
  - The sign of each original operand is also latched.
- FREE, any other input: stay in FREE; ready_o=0, result_o=0.
- DIVBYZERO: next state END; result register = 0.
- ON, annul_i=1: -> FREE next cycle; result discarded, ready_o=0.
- ON, annul_i=0, one iteration per cycle:
  - partial = {rem[WIDTH-2:0], dividend_msb} - divisor.
  - If partial is non-negative: rem=partial, shift 1 into the quotient; else restore and shift 0.
  - cnt increments.
- ON, on the iteration with cnt==WIDTH-1: final values are sign-corrected and registered into the result, then state -> END.
  - Signed: quotient is negated if the operand signs differ; remainder is negated if the dividend was negative.
  - Unsigned: no correction.
- END: ready_o=1 and result_o=result register.
  - start_i=0 -> FREE next cycle; ready_o=0 and result_o=0 in that cycle.
  - start_i=1 -> hold END; output stable.
  - annul_i=1 in END -> FREE.
- Latency (start accepted in cycle T0):
  - normal: ON in T1..T32, ready_o=1 from T33.
  - divide-by-zero: DIVBYZERO in T1, ready_o=1 from T2.
- Operand changes after T0 have no effect until the next start is accepted in FREE.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient=0x80000000, remainder=0; no trap.
- annul_i and start_i both high in FREE: annul wins, no start.
- result_o and ready_o are registered; only stallreq_o is combinational.

Test Plan:
- DIVU 100/7: start at T0, hold start_i -> ready_o rises at T33; result_o=0x00000002_0000000E; stallreq_o=1 in T0..T32 and 0 from T33.
- DIV -7/2 (0xFFFFFFF9/0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD; DIV 7/-2 -> 0x00000001_FFFFFFFD.
- DIV 0x80000000/0xFFFFFFFF -> result_o=0x00000000_80000000 at T33; DIVU 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
- Divide-by-zero, 5/0 -> ready_o=1 at T2, result_o=0. Then drop start_i -> FREE, ready_o=0 the next cycle; a new 9/3 completes with result 0x00000000_00000003.
- annul_i pulsed at T10 of a running division -> FREE at T11, ready_o never asserted. A start at T12 for 20/6 -> ready_o at T45, result 0x00000002_00000003.
- rst asserted at T15 of a division -> next cycle state=FREE, ready_o=0, result_o=0; the divider accepts a fresh start immediately after rst drops.

Source files
------------

// File: rtl/div_seq.sv
// Radix-2 restoring sequential divider for the EX stage: produces the HI/LO pair
// {remainder, quotient} for DIV/DIVU and requests a pipeline stall while busy.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]      CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]      CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   OP_ZERO   = {WIDTH{1'b0}};
  localparam logic [2*WIDTH-1:0] RES_ZERO  = {(2*WIDTH){1'b0}};

  typedef enum logic [1:0] {
    ST_FREE      = 2'b00,
    ST_DIVBYZERO = 2'b01,
    ST_ON        = 2'b10,
    ST_END       = 2'b11
  } state_t;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    f_neg = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic is_signed);
    f_mag = (is_signed && v[WIDTH-1]) ? f_neg(v) : v;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_dvd, w_dvd_nxt;
  logic [WIDTH-1:0]   r_dvs, w_dvs_nxt;
  logic [WIDTH-1:0]   r_rem, w_rem_nxt;
  logic [WIDTH-1:0]   r_quot, w_quot_nxt;
  logic               r_signed, w_signed_nxt;
  logic               r_sign1, w_sign1_nxt;
  logic               r_sign2, w_sign2_nxt;
  logic [2*WIDTH-1:0] r_result, w_result_nxt;
  logic               r_ready, w_ready_nxt;

  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_rem_step;
  logic [WIDTH-1:0]   w_quot_step;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quot_fix;

  // One extra bit on the trial subtraction: a set top bit means it went negative and we restore.
  assign w_diff      = {1'b0, r_rem[WIDTH-2:0], r_dvd[WIDTH-1]} - {1'b0, r_dvs};
  assign w_rem_step  = w_diff[WIDTH] ? {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]} : w_diff[WIDTH-1:0];
  assign w_quot_step = {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_quot_fix  = (r_signed && (r_sign1 ^ r_sign2)) ? f_neg(w_quot_step) : w_quot_step;
  assign w_rem_fix   = (r_signed && r_sign1) ? f_neg(w_rem_step) : w_rem_step;

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = start_i & ~r_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dvd_nxt    = r_dvd;
    w_dvs_nxt    = r_dvs;
    w_rem_nxt    = r_rem;
    w_quot_nxt   = r_quot;
    w_signed_nxt = r_signed;
    w_sign1_nxt  = r_sign1;
    w_sign2_nxt  = r_sign2;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;
    case (r_state)
      ST_FREE: begin
        w_ready_nxt  = 1'b0;
        w_result_nxt = RES_ZERO;
        if (start_i && !annul_i) begin
          w_cnt_nxt    = CNT_ZERO;
          w_rem_nxt    = OP_ZERO;
          w_quot_nxt   = OP_ZERO;
          w_signed_nxt = signed_div_i;
          w_sign1_nxt  = opdata1_i[WIDTH-1];
          w_sign2_nxt  = opdata2_i[WIDTH-1];
          w_dvd_nxt    = f_mag(opdata1_i, signed_div_i);
          w_dvs_nxt    = f_mag(opdata2_i, signed_div_i);
          if (opdata2_i == OP_ZERO) begin
            w_state_nxt = ST_DIVBYZERO;
          end else begin
            w_state_nxt = ST_ON;
          end
        end else begin
          w_state_nxt = ST_FREE;
        end
      end
      ST_DIVBYZERO: begin
        w_state_nxt  = ST_END;
        w_result_nxt = RES_ZERO;
        w_ready_nxt  = 1'b1;
      end
      ST_ON: begin
        if (annul_i) begin
          w_state_nxt  = ST_FREE;
          w_ready_nxt  = 1'b0;
          w_result_nxt = RES_ZERO;
        end else begin
          w_rem_nxt  = w_rem_step;
          w_quot_nxt = w_quot_step;
          w_dvd_nxt  = {r_dvd[WIDTH-2:0], 1'b0};
          w_cnt_nxt  = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            w_result_nxt = {w_rem_fix, w_quot_fix};
            w_ready_nxt  = 1'b1;
            w_state_nxt  = ST_END;
          end else begin
            w_state_nxt = ST_ON;
          end
        end
      end
      ST_END: begin
        if (annul_i || !start_i) begin
          w_state_nxt  = ST_FREE;
          w_ready_nxt  = 1'b0;
          w_result_nxt = RES_ZERO;
        end else begin
          w_state_nxt = ST_END;
        end
      end
      default: begin
        w_state_nxt  = ST_FREE;
        w_ready_nxt  = 1'b0;
        w_result_nxt = RES_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_FREE;
      r_cnt    <= CNT_ZERO;
      r_dvd    <= OP_ZERO;
      r_dvs    <= OP_ZERO;
      r_rem    <= OP_ZERO;
      r_quot   <= OP_ZERO;
      r_signed <= 1'b0;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_result <= RES_ZERO;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dvd    <= w_dvd_nxt;
      r_dvs    <= w_dvs_nxt;
      r_rem    <= w_rem_nxt;
      r_quot   <= w_quot_nxt;
      r_signed <= w_signed_nxt;
      r_sign1  <= w_sign1_nxt;
      r_sign2  <= w_sign2_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_pass   = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division (C semantics: truncate toward zero).
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge with the DUT in FREE; returns at a negedge with the DUT back in FREE.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    logic [63:0] exp;
    int lat;
    int exp_lat;
    exp     = model(a, b, s);
    exp_lat = (b == 32'd0) ? 2 : 33;
    start_i = 1'b1; annul_i = 1'b0; signed_div_i = s; opdata1_i = a; opdata2_i = b;
    #1;
    check_eq({tag, "_stall_t0"}, {63'd0, stallreq_o}, 64'd1);
    check_eq({tag, "_ready_t0"}, {63'd0, ready_o}, 64'd0);
    lat = 0;
    while (!ready_o && lat < 100) begin
      @(negedge clk);
      lat++;
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      #1;
      if (!ready_o) check_eq({tag, "_stall_busy"}, {63'd0, stallreq_o}, 64'd1);
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_result"}, result_o, exp);
    check_eq({tag, "_stall_done"}, {63'd0, stallreq_o}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq({tag, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
      check_eq({tag, "_hold_result"}, result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    check_eq({tag, "_free_ready"}, {63'd0, ready_o}, 64'd0);
    check_eq({tag, "_free_result"}, result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    bit          seen_ready;
    int          k;

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_ready", {63'd0, ready_o}, 64'd0);
    check_eq("reset_result", result_o, 64'd0);
    check_eq("reset_stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div(32'd100, 32'd7, 1'b0, "divu_100_7");
    check_eq("model_100_7", model(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, "div_m7_2");
    do_div(32'd7, 32'hFFFFFFFE, 1'b1, "div_7_m2");
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "div_ovf");
    do_div(32'hFFFFFFFF, 32'd1, 1'b0, "divu_max_1");
    do_div(32'd5, 32'd0, 1'b0, "div_by_zero");
    do_div(32'd9, 32'd3, 1'b0, "div_9_3");
    do_div(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "divu_big");

    // Annul mid-division, then a fresh start one cycle after returning to FREE.
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7;
    seen_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ready_o) seen_ready = 1'b1;
    end
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    if (ready_o) seen_ready = 1'b1;
    check_eq("annul_result", result_o, 64'd0);
    check_eq("annul_no_ready", {63'd0, seen_ready}, 64'd0);
    @(negedge clk);
    do_div(32'd20, 32'd6, 1'b0, "after_annul");

    // Annul while holding a finished result, then annul beats start in FREE.
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
    k = 0;
    while (!ready_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("end_annul_lat", 64'(k), 64'd33);
    annul_i = 1'b1;
    @(negedge clk);
    check_eq("end_annul_ready", {63'd0, ready_o}, 64'd0);
    check_eq("end_annul_result", result_o, 64'd0);
    @(negedge clk);
    check_eq("annul_wins_ready", {63'd0, ready_o}, 64'd0);
    check_eq("annul_wins_stall", {63'd0, stallreq_o}, 64'd1);
    annul_i = 1'b0; start_i = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("annul_wins_idle", {63'd0, ready_o}, 64'd0);

    // Synchronous reset in the middle of a division.
    start_i = 1'b1; signed_div_i = 1'b1; opdata1_i = 32'hFFFF0000; opdata2_i = 32'd3;
    repeat (15) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    check_eq("midrst_ready", {63'd0, ready_o}, 64'd0);
    check_eq("midrst_result", result_o, 64'd0);
    rst = 1'b0;
    do_div(32'd20, 32'd6, 1'b0, "after_rst");

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; rs = 1'b1; end
        2: rb = rb >> $urandom_range(8, 31);
        default: ra = ra;
      endcase
      do_div(ra, rb, rs, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
